// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus: registered one-cycle grant pulse plus ownership tracking.
// Define BUS_ARBITER_WATCHDOG_EN to compile in the stall watchdog, ABORT state and abort strobes.

module bus_arbiter_rr #(
  parameter int          NUM_REQ         = 4,
  parameter logic [15:0] WATCHDOG_CYCLES = 16'd256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] requestTransaction,
  output logic [NUM_REQ-1:0] transactionGranted,
  input  logic               beginTransactionIn,
  input  logic               endTransactionIn,
  input  logic               dataValidIn,
  input  logic               busErrorIn,
  output logic [3:0]         busOwner,
  output logic               busOwnerValid,
  output logic               endTransactionOut,
  output logic               busErrorOut
);

`ifdef BUS_ARBITER_WATCHDOG_EN
  typedef enum logic [2:0] {IDLE, GRANT, WAIT_BEGIN, BUSY, ABORT} state_t;
  logic [15:0] wd_reg, wd_next;
  logic        abort_reg, abort_next;
  logic        expired;
`else
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_BEGIN, BUSY} state_t;
`endif

  state_t             state_reg, state_next;
  logic [3:0]         ptr_reg, owner_reg, winner;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic               valid_reg, valid_next;
  logic [NUM_REQ-1:0] rotated;
  logic               release_bus;

  assign release_bus = endTransactionIn | busErrorIn;

  // Rotate the requests so bit 0 is the master just after the last winner.
  always_comb begin
    logic [5:0] sum;
    logic       found;
    rotated = NUM_REQ'({requestTransaction, requestTransaction} >> (5'(ptr_reg) + 5'd1));
    found   = 1'b0;
    winner  = ptr_reg;
    sum     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rotated[j]) begin
        found = 1'b1;
        sum   = 6'(ptr_reg) + 6'd1 + 6'(j);
        if (sum >= 6'(NUM_REQ)) sum = sum - 6'(NUM_REQ);
        winner = 4'(sum);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 4'(NUM_REQ - 1);
      owner_reg <= '0;
      grant_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      valid_reg <= valid_next;
      if (state_reg == IDLE && |requestTransaction) begin
        ptr_reg   <= winner;
        owner_reg <= winner;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (|requestTransaction) state_next = GRANT;
      GRANT:      state_next = WAIT_BEGIN;
      WAIT_BEGIN: begin
        if (release_bus) state_next = IDLE;
`ifdef BUS_ARBITER_WATCHDOG_EN
        else if (expired) state_next = ABORT;
`endif
        else if (beginTransactionIn) state_next = BUSY;
      end
      BUSY: begin
        if (release_bus) state_next = IDLE;
`ifdef BUS_ARBITER_WATCHDOG_EN
        else if (expired) state_next = ABORT;
`endif
      end
`ifdef BUS_ARBITER_WATCHDOG_EN
      ABORT:      state_next = IDLE;
`endif
      default:    state_next = IDLE;
    endcase
  end

  // The grant register is loaded while in GRANT, so the pulse lands one cycle later.
  always_comb begin
    grant_next = '0;
    if (state_reg == GRANT) grant_next = NUM_REQ'(1'b1) << owner_reg;
    valid_next = (state_next != IDLE);
`ifdef BUS_ARBITER_WATCHDOG_EN
    abort_next = (state_next == ABORT);
`endif
  end

  assign transactionGranted = grant_reg;
  assign busOwner           = owner_reg;
  assign busOwnerValid      = valid_reg;

`ifdef BUS_ARBITER_WATCHDOG_EN
  assign expired = (wd_reg == WATCHDOG_CYCLES);

  always_comb begin
    wd_next = wd_reg;
    if (state_next == GRANT || beginTransactionIn || dataValidIn)
      wd_next = '0;
    else if ((state_reg == WAIT_BEGIN || state_reg == BUSY) && !expired)
      wd_next = wd_reg + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_reg    <= '0;
      abort_reg <= 1'b0;
    end else begin
      wd_reg    <= wd_next;
      abort_reg <= abort_next;
    end
  end

  assign endTransactionOut = abort_reg;
  assign busErrorOut       = abort_reg;
`else
  logic unused_watchdog;
  assign unused_watchdog   = ^{dataValidIn, WATCHDOG_CYCLES};
  assign endTransactionOut = 1'b0;
  assign busErrorOut       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a driver pushes the expected winner of each arbitration,
// a negedge monitor pops and compares whenever a grant pulse appears.

module tb_bus_arbiter_rr;
  localparam int          N  = 4;
  localparam logic [15:0] WD = 16'd8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] requestTransaction = '0;
  logic         beginTransactionIn = 1'b0;
  logic         endTransactionIn   = 1'b0;
  logic         dataValidIn        = 1'b0;
  logic         busErrorIn         = 1'b0;
  logic [N-1:0] transactionGranted;
  logic [3:0]   busOwner;
  logic         busOwnerValid;
  logic         endTransactionOut;
  logic         busErrorOut;

  int           checks = 0;
  int           passes = 0;
  int           exp_q[$];
  int           last_winner = N - 1;
  logic [N-1:0] pend = '0;
  bit           stop = 1'b0;

  bus_arbiter_rr #(.NUM_REQ(N), .WATCHDOG_CYCLES(WD)) dut (
    .clock              (clock),
    .reset              (reset),
    .requestTransaction (requestTransaction),
    .transactionGranted (transactionGranted),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .dataValidIn        (dataValidIn),
    .busErrorIn         (busErrorIn),
    .busOwner           (busOwner),
    .busOwnerValid      (busOwnerValid),
    .endTransactionOut  (endTransactionOut),
    .busErrorOut        (busErrorOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference rule: first requester strictly after the last winner, wrapping around.
  function automatic int pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) begin
      int c = (last + i) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (transactionGranted != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(transactionGranted), 0);
      end else begin
        int w;
        w = exp_q.pop_front();
        check("grant_vector", 32'(transactionGranted), 32'(1) << w);
        check("grant_owner", 32'(busOwner), 32'(w));
        $display("grant: master %0d vector %b owner %0d", w, transactionGranted, busOwner);
      end
    end
  end

  task automatic wait_pulse(input string name, input int lat);
    int waited = 0;
    while (transactionGranted == '0 && waited < lat + 6) begin
      tick();
      waited++;
    end
    check(name, 32'(waited), 32'(lat));
    if (transactionGranted == '0) begin
      $display("FAIL %s: no grant pulse within %0d cycles", name, lat + 6);
      stop = 1'b1;
    end
  endtask

  task automatic start_txn(input int lat, output int w);
    w = pick(pend, last_winner);
    exp_q.push_back(w);
    last_winner = w;
    wait_pulse("grant_latency", lat);
    if (!stop) check("valid_at_grant", 32'(busOwnerValid), 1);
  endtask

  task automatic body_txn(input int kind, input int d, input int beats);
    repeat (d) tick();
    case (kind)
      0: begin
        beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
        repeat (beats) begin dataValidIn = 1'b1; tick(); end
        dataValidIn = 1'b0;
        endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
      end
      1: begin endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0; end
      2: begin busErrorIn = 1'b1; tick(); busErrorIn = 1'b0; end
      3: begin
        beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
        repeat (beats) begin dataValidIn = 1'b1; tick(); end
        dataValidIn = 1'b0;
        busErrorIn = 1'b1; tick(); busErrorIn = 1'b0;
      end
      default: begin
        beginTransactionIn = 1'b1; endTransactionIn = 1'b1; tick();
        beginTransactionIn = 1'b0; endTransactionIn = 1'b0;
      end
    endcase
    check("valid_after_end", 32'(busOwnerValid), 0);
    check("no_abort_strobe", 32'({endTransactionOut, busErrorOut}), 0);
  endtask

  task automatic run_txn(input int kind, input int d, input int beats,
                         input logic [N-1:0] add, input bit readd);
    int w;
    start_txn(2, w);
    if (stop) return;
    if (!readd) pend[w] = 1'b0;
    pend = pend | add;
    requestTransaction = pend;
    $display("txn: master %0d kind %0d delay %0d beats %0d pending %b", w, kind, d, beats, pend);
    body_txn(kind, d, beats);
  endtask

  task automatic watchdog_test();
    int w;
    start_txn(2, w);
    if (stop) return;
    pend[w] = 1'b0;
    requestTransaction = pend;
    beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
`ifdef BUS_ARBITER_WATCHDOG_EN
    repeat (int'(WD)) tick();
    check("wd_before_expiry_strobe", 32'(endTransactionOut), 0);
    check("wd_before_expiry_valid", 32'(busOwnerValid), 1);
    tick();
    check("wd_abort_end", 32'(endTransactionOut), 1);
    check("wd_abort_err", 32'(busErrorOut), 1);
    check("wd_abort_valid", 32'(busOwnerValid), 1);
    tick();
    check("wd_after_abort_strobes", 32'({endTransactionOut, busErrorOut}), 0);
    check("wd_after_abort_valid", 32'(busOwnerValid), 0);
    $display("watchdog: abort sequence observed for master %0d", w);
    // End arriving in the expiry cycle wins over the abort.
    if (pend == '0) begin pend = 4'b0100; requestTransaction = pend; end
    start_txn(2, w);
    if (stop) return;
    pend[w] = 1'b0;
    requestTransaction = pend;
    beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
    repeat (int'(WD)) tick();
    endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    check("wd_end_priority_strobes", 32'({endTransactionOut, busErrorOut}), 0);
    check("wd_end_priority_valid", 32'(busOwnerValid), 0);
    $display("watchdog: end at expiry released master %0d without abort", w);
`else
    repeat (1000) tick();
    check("stall_hold_valid", 32'(busOwnerValid), 1);
    check("stall_hold_strobes", 32'({endTransactionOut, busErrorOut}), 0);
    endTransactionIn = 1'b1; tick(); endTransactionIn = 1'b0;
    check("stall_release_valid", 32'(busOwnerValid), 0);
    $display("stall: master %0d held bus for 1000 cycles", w);
`endif
  endtask

  initial begin
    int w;
    requestTransaction = '1;  // must be ignored while reset is low
    #1 reset = 1'b0;
    repeat (2) tick();
    check("rst_grant", 32'(transactionGranted), 0);
    check("rst_owner", 32'(busOwner), 0);
    check("rst_valid", 32'(busOwnerValid), 0);
    check("rst_end_out", 32'(endTransactionOut), 0);
    check("rst_err_out", 32'(busErrorOut), 0);
    requestTransaction = '0;
    reset = 1'b1;

    // Single master with three data beats.
    pend = 4'b0100; requestTransaction = pend;
    run_txn(0, 0, 3, '0, 1'b0);

    // Master 2 drops its request during its own GRANT cycle.
    if (!stop) begin
      pend = 4'b0100; requestTransaction = pend;
      w = pick(pend, last_winner);
      exp_q.push_back(w); last_winner = w;
      tick();
      pend = '0; requestTransaction = '0;
      wait_pulse("drop_latency", 1);
      if (!stop) body_txn(0, 0, 1);
    end

    // Abandon, then the other requester follows.
    if (!stop) begin
      pend = 4'b0011; requestTransaction = pend;
      run_txn(1, 0, 0, '0, 1'b0);
      if (!stop) run_txn(0, 1, 0, '0, 1'b0);
    end

    // Master 3 arrives while master 1 owns the bus.
    if (!stop) begin
      pend = 4'b0010; requestTransaction = pend;
      run_txn(0, 0, 2, 4'b1000, 1'b0);
      if (!stop) run_txn(0, 0, 0, '0, 1'b0);
    end

    if (!stop) begin
      pend = 4'b0001; requestTransaction = pend;
      watchdog_test();
    end

    for (int t = 0; t < 80 && !stop; t++) begin
      if (pend == '0) begin
        repeat ($urandom_range(0, 2)) tick();
        pend = N'($urandom_range(1, (1 << N) - 1));
        requestTransaction = pend;
      end
      run_txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              N'($urandom_range(0, (1 << N) - 1)) & N'($urandom), 1'b0);
    end
    pend = '0; requestTransaction = '0;

    // Reset in BUSY, then all four masters request continuously.
    if (!stop) begin
      pend = 4'b1000; requestTransaction = pend;
      start_txn(2, w);
      pend = '0; requestTransaction = '0;
      beginTransactionIn = 1'b1; tick(); beginTransactionIn = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midrst_grant", 32'(transactionGranted), 0);
      check("midrst_owner", 32'(busOwner), 0);
      check("midrst_valid", 32'(busOwnerValid), 0);
      check("midrst_strobes", 32'({endTransactionOut, busErrorOut}), 0);
      tick();
      last_winner = N - 1;
      pend = '1; requestTransaction = pend;
      reset = 1'b1;
      for (int k = 0; k < 5 && !stop; k++) run_txn(0, 0, 0, '0, 1'b1);
      pend = '0; requestTransaction = '0;
    end

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
